// File: rtl/ps_symbols.sv
// ----------------------------------------------------------------------------
// ps_symbols
// Shared constants for the paralelo-serial sequencer: the line symbols the
// converter understands and the FSM state encodings (also visible on the
// state_out debug port). Also provides a helper that sizes a counter for a
// given terminal count (never narrower than one bit).
// ----------------------------------------------------------------------------
package ps_symbols;

    // Filler symbol; also what the line carries while training.
    localparam logic [7:0] IDL_SYM  = 8'hBC;
    // Skip symbol used to build SKP ordered sets.
    localparam logic [7:0] SKP_SYM  = 8'h1C;

    // FSM encodings; 2'd3 is illegal and recovers to TRAIN.
    localparam logic [1:0] ST_TRAIN = 2'd0;
    localparam logic [1:0] ST_LINK  = 2'd1;
    localparam logic [1:0] ST_SKIP  = 2'd2;

    // Width of a counter that runs 0 .. terminal-1.
    function automatic int cnt_width(input int terminal);
        return (terminal <= 1) ? 1 : $clog2(terminal);
    endfunction

endpackage

// File: rtl/ps_skp_timer.sv
// ----------------------------------------------------------------------------
// ps_skp_timer
// Timing for SKP ordered-set insertion. The interval counter runs while the
// sequencer is in LINK and flags skp_due_o on the last LINK cycle of each
// interval; the length counter runs while in SKIP and flags skp_done_o on the
// last symbol of the ordered set. Both counters return to zero on their
// terminal count and are held at zero while clear_i is high.
//
// Ports:
//   clk_4f      byte clock
//   reset_L     asynchronous active-low reset
//   clear_i     hold both counters at zero (sequencer outside LINK/SKIP)
//   link_i      sequencer is in LINK this cycle
//   skip_i      sequencer is in SKIP this cycle
//   skp_due_o   this LINK cycle ends the interval
//   skp_done_o  this SKIP cycle emits the last symbol of the ordered set
// ----------------------------------------------------------------------------
module ps_skp_timer
    import ps_symbols::*;
#(
    parameter int SKP_INTERVAL = 64,
    parameter int SKP_LEN      = 4
) (
    input  logic clk_4f,
    input  logic reset_L,
    input  logic clear_i,
    input  logic link_i,
    input  logic skip_i,
    output logic skp_due_o,
    output logic skp_done_o
);

    localparam int INT_W = cnt_width(SKP_INTERVAL);
    localparam int LEN_W = cnt_width(SKP_LEN);
    localparam logic [INT_W-1:0] INT_LAST = INT_W'(SKP_INTERVAL - 1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(SKP_LEN - 1);

    logic [INT_W-1:0] int_cnt_q, int_cnt_d;
    logic [LEN_W-1:0] skp_cnt_q, skp_cnt_d;

    assign skp_due_o  = link_i && (int_cnt_q == INT_LAST);
    assign skp_done_o = skip_i && (skp_cnt_q == LEN_LAST);

    // Next-count logic: each counter advances only in its own state and
    // restarts from zero once it reaches its terminal value, so it never
    // wraps through unused codes.
    always_comb begin
        int_cnt_d = int_cnt_q;
        skp_cnt_d = skp_cnt_q;
        if (clear_i) begin
            int_cnt_d = '0;
            skp_cnt_d = '0;
        end else begin
            if (link_i) begin
                int_cnt_d = skp_due_o ? '0 : int_cnt_q + 1'b1;
            end
            if (skip_i) begin
                skp_cnt_d = skp_done_o ? '0 : skp_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers, cleared asynchronously on reset.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            int_cnt_q <= '0;
            skp_cnt_q <= '0;
        end else begin
            int_cnt_q <= int_cnt_d;
            skp_cnt_q <= skp_cnt_d;
        end
    end

endmodule

// File: rtl/control_paraleloserial.sv
// ----------------------------------------------------------------------------
// control_paraleloserial
// Sequencer in front of the paralelo-serial converter. After link-up it keeps
// the lane in idle training for MIN_IDLE enabled cycles, then passes upstream
// bytes through a valid/ready handshake and inserts an SKP ordered set of
// SKP_LEN symbols every SKP_INTERVAL LINK cycles, stalling upstream meanwhile.
// It is the only driver of the converter's active input.
//
// Ports:
//   clk_4f      byte clock, all logic on its rising edge
//   reset_L     asynchronous active-low reset
//   enable      link enable from the upper layer
//   data_in     upstream byte, qualified by valid_in
//   valid_in    data_in is valid
//   ready_out   byte can be accepted this cycle (combinational)
//   data_out    registered parallel byte to the converter
//   active      registered converter enable (0 = converter emits IDL)
//   state_out   current FSM state, for debug
//   stat_bytes  (CTRL_PS_STATS_EN only) saturating count of accepted bytes
//   stat_skp    (CTRL_PS_STATS_EN only) saturating count of completed SKP sets
//
// Build option: define CTRL_PS_STATS_EN to add the statistics outputs.
// ----------------------------------------------------------------------------
module control_paraleloserial
    import ps_symbols::*;
#(
    parameter int MIN_IDLE     = 16,
    parameter int SKP_INTERVAL = 64,
    parameter int SKP_LEN      = 4
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       active,
    output logic [1:0] state_out
`ifdef CTRL_PS_STATS_EN
    ,
    output logic [15:0] stat_bytes,
    output logic [15:0] stat_skp
`endif
);

    localparam int IDLE_W = cnt_width(MIN_IDLE);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(MIN_IDLE - 1);

    logic [1:0]        state_q, state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              active_q, active_d;
    logic              xfer;
    logic              skp_due, skp_done;
    logic              in_link, in_skip;

    assign in_link   = (state_q == ST_LINK);
    assign in_skip   = (state_q == ST_SKIP);
    assign ready_out = in_link && enable;
    assign xfer      = valid_in && ready_out;
    assign data_out  = data_q;
    assign active    = active_q;
    assign state_out = state_q;

    // Interval and ordered-set length counting. Counters are held at zero
    // whenever we are not in LINK or SKIP, so every LINK entry from TRAIN
    // starts a fresh interval.
    ps_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_LEN      (SKP_LEN)
    ) u_skp_timer (
        .clk_4f     (clk_4f),
        .reset_L    (reset_L),
        .clear_i    (!(in_link || in_skip)),
        .link_i     (in_link),
        .skip_i     (in_skip),
        .skp_due_o  (skp_due),
        .skp_done_o (skp_done)
    );

    // FSM next state and next output register values. Defaults describe an
    // idle line (converter off, IDL symbol) with the idle counter cleared.
    // Dropping enable in LINK wins over a due SKP; dropping it in SKIP only
    // takes effect once the ordered set is complete.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        data_d     = IDL_SYM;
        active_d   = 1'b0;
        case (state_q)
            ST_TRAIN: begin
                if (enable) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = ST_LINK;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            ST_LINK: begin
                if (!enable) begin
                    state_d = ST_TRAIN;
                end else begin
                    active_d = 1'b1;
                    if (xfer) begin
                        data_d = data_in;
                    end
                    if (skp_due) begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                active_d = 1'b1;
                data_d   = SKP_SYM;
                if (skp_done) begin
                    state_d = enable ? ST_LINK : ST_TRAIN;
                end
            end
            default: begin
                state_d = ST_TRAIN;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight byte.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_TRAIN;
            idle_cnt_q <= '0;
            data_q     <= IDL_SYM;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            data_q     <= data_d;
            active_q   <= active_d;
        end
    end

`ifdef CTRL_PS_STATS_EN
    logic [15:0] stat_bytes_q, stat_bytes_d;
    logic [15:0] stat_skp_q, stat_skp_d;

    assign stat_bytes = stat_bytes_q;
    assign stat_skp   = stat_skp_q;

    // Statistics: saturating counts, wiped while the link is held down in
    // TRAIN. Transfers and SKP completions never coincide with that clear.
    always_comb begin
        stat_bytes_d = stat_bytes_q;
        stat_skp_d   = stat_skp_q;
        if ((state_q == ST_TRAIN) && !enable) begin
            stat_bytes_d = '0;
            stat_skp_d   = '0;
        end else begin
            if (xfer && (stat_bytes_q != 16'hFFFF)) begin
                stat_bytes_d = stat_bytes_q + 16'd1;
            end
            if (skp_done && (stat_skp_q != 16'hFFFF)) begin
                stat_skp_d = stat_skp_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            stat_bytes_q <= '0;
            stat_skp_q   <= '0;
        end else begin
            stat_bytes_q <= stat_bytes_d;
            stat_skp_q   <= stat_skp_d;
        end
    end
`endif

endmodule

// File: tb/tb_control_paraleloserial.sv
// ----------------------------------------------------------------------------
// tb_control_paraleloserial
// Self-checking bench for control_paraleloserial with default parameters
// (MIN_IDLE=16, SKP_INTERVAL=64, SKP_LEN=4). Accepted bytes are pushed to a
// scoreboard queue at the handshake and popped when they appear on data_out.
// Statistics checks are included when CTRL_PS_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_control_paraleloserial;

    localparam logic [7:0] IDL = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;

    logic       clk_4f = 1'b0;
    logic       reset_L;
    logic       enable;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] data_out;
    logic       active;
    logic [1:0] state_out;
`ifdef CTRL_PS_STATS_EN
    logic [15:0] stat_bytes;
    logic [15:0] stat_skp;
`endif

    int         nCompared   = 0;
    int         nMismatched = 0;
    logic [7:0] expQ[$];
    logic [7:0] expByte;
    logic       lastAcc;
    logic [7:0] nextByte;

    control_paraleloserial dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .enable    (enable),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .active    (active),
        .state_out (state_out)
`ifdef CTRL_PS_STATS_EN
        ,
        .stat_bytes (stat_bytes),
        .stat_skp   (stat_skp)
`endif
    );

    // 10-unit byte clock.
    always #5 clk_4f = ~clk_4f;

    // One clock: record a handshake (pushing the byte to the scoreboard),
    // then advance to just after the next rising edge.
    task automatic step();
        #1;
        lastAcc = valid_in && ready_out;
        if (lastAcc) expQ.push_back(data_in);
        @(posedge clk_4f);
        #1;
    endtask

    task automatic test_reset();
        reset_L  = 1'b0;
        enable   = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(posedge clk_4f);
        #1;
        nCompared++;
        if (state_out !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_state got %0d want 0", state_out); end
        nCompared++;
        if ({active, data_out} !== {1'b0, IDL}) begin nMismatched++; $display("[TB] FAIL reset_out got active=%b data=%h want active=0 data=%h", active, data_out, IDL); end
        enable = 1'b1;
        #1;
        nCompared++;
        if (ready_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ready got %b want 0", ready_out); end
`ifdef CTRL_PS_STATS_EN
        nCompared++;
        if ({stat_bytes, stat_skp} !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_stats got %h/%h want 0/0", stat_bytes, stat_skp); end
`endif
        reset_L = 1'b1;
    endtask

    // enable held from reset release: 16 TRAIN cycles, then LINK.
    task automatic test_train();
        for (int k = 1; k <= 16; k++) begin
            step();
            nCompared++;
            if (state_out !== ((k < 16) ? 2'd0 : 2'd1)) begin nMismatched++; $display("[TB] FAIL train_state k=%0d got %0d want %0d", k, state_out, (k < 16) ? 0 : 1); end
            nCompared++;
            if ({active, data_out} !== {1'b0, IDL}) begin nMismatched++; $display("[TB] FAIL train_out k=%0d got active=%b data=%h want active=0 data=%h", k, active, data_out, IDL); end
        end
        nCompared++;
        if (ready_out !== 1'b1) begin nMismatched++; $display("[TB] FAIL train_ready got %b want 1", ready_out); end
        step();
        nCompared++;
        if ({active, data_out} !== {1'b1, IDL}) begin nMismatched++; $display("[TB] FAIL link_first got active=%b data=%h want active=1 data=%h", active, data_out, IDL); end
    endtask

    // Bytes 01..0A back to back, then two idle gaps (LINK edges 2..13).
    task automatic test_link_data();
        valid_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            data_in = 8'(i);
            step();
            nCompared++;
            if (lastAcc !== 1'b1) begin nMismatched++; $display("[TB] FAIL link_accept i=%0d got %b want 1", i, lastAcc); end
            if (expQ.size() > 0) expByte = expQ.pop_front(); else expByte = 'x;
            nCompared++;
            if ({active, data_out} !== {1'b1, expByte}) begin nMismatched++; $display("[TB] FAIL link_data i=%0d got active=%b data=%h want active=1 data=%h", i, active, data_out, expByte); end
        end
        valid_in = 1'b0;
        repeat (2) begin
            step();
            nCompared++;
            if ({active, data_out} !== {1'b1, IDL}) begin nMismatched++; $display("[TB] FAIL link_gap got active=%b data=%h want active=1 data=%h", active, data_out, IDL); end
        end
    endtask

    // Continuous valid through LINK edge 64, the 4-symbol SKP set, and back.
    task automatic test_skp_insertion();
        nextByte = 8'h20;
        valid_in = 1'b1;
        for (int e = 14; e <= 64; e++) begin
            data_in = nextByte;
            step();
            if (lastAcc) nextByte++;
            nCompared++;
            if (lastAcc !== 1'b1) begin nMismatched++; $display("[TB] FAIL skp_pre_accept e=%0d got %b want 1", e, lastAcc); end
            if (expQ.size() > 0) expByte = expQ.pop_front(); else expByte = 'x;
            nCompared++;
            if (data_out !== expByte) begin nMismatched++; $display("[TB] FAIL skp_pre_data e=%0d got %h want %h", e, data_out, expByte); end
        end
        nCompared++;
        if (state_out !== 2'd2) begin nMismatched++; $display("[TB] FAIL skp_enter_state got %0d want 2", state_out); end
        for (int s = 1; s <= 4; s++) begin
            data_in = nextByte;
            nCompared++;
            if (ready_out !== 1'b0) begin nMismatched++; $display("[TB] FAIL skp_ready s=%0d got %b want 0", s, ready_out); end
            step();
            if (lastAcc) nextByte++;
            nCompared++;
            if ({active, data_out} !== {1'b1, SKP}) begin nMismatched++; $display("[TB] FAIL skp_sym s=%0d got active=%b data=%h want active=1 data=%h", s, active, data_out, SKP); end
        end
        nCompared++;
        if ({state_out, ready_out} !== {2'd1, 1'b1}) begin nMismatched++; $display("[TB] FAIL skp_exit got state=%0d ready=%b want state=1 ready=1", state_out, ready_out); end
        data_in = nextByte;
        step();
        nextByte++;
        if (expQ.size() > 0) expByte = expQ.pop_front(); else expByte = 'x;
        nCompared++;
        if (data_out !== expByte || expByte !== 8'h53) begin nMismatched++; $display("[TB] FAIL skp_resume got %h queued %h want 53", data_out, expByte); end
        nCompared++;
        if (expQ.size() != 0) begin nMismatched++; $display("[TB] FAIL skp_queue got %0d leftover want 0", expQ.size()); end
        valid_in = 1'b0;
    endtask

    // Reach the next SKP, drop enable on its 2nd symbol, then retrain.
    task automatic test_enable_drop_skip();
        for (int e = 2; e <= 64; e++) begin
            step();
            nCompared++;
            if ({active, data_out} !== {1'b1, IDL}) begin nMismatched++; $display("[TB] FAIL drop_link e=%0d got active=%b data=%h want active=1 data=%h", e, active, data_out, IDL); end
        end
        step();
        enable = 1'b0;
        for (int s = 2; s <= 4; s++) begin
            step();
            nCompared++;
            if ({active, data_out} !== {1'b1, SKP}) begin nMismatched++; $display("[TB] FAIL drop_sym s=%0d got active=%b data=%h want active=1 data=%h", s, active, data_out, SKP); end
        end
        nCompared++;
        if (state_out !== 2'd0) begin nMismatched++; $display("[TB] FAIL drop_state got %0d want 0", state_out); end
        step();
        nCompared++;
        if ({active, data_out} !== {1'b0, IDL}) begin nMismatched++; $display("[TB] FAIL drop_idle got active=%b data=%h want active=0 data=%h", active, data_out, IDL); end
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            nCompared++;
            if (state_out !== ((k < 16) ? 2'd0 : 2'd1)) begin nMismatched++; $display("[TB] FAIL drop_retrain k=%0d got %0d want %0d", k, state_out, (k < 16) ? 0 : 1); end
        end
    endtask

    // Leave LINK, then a one-cycle enable glitch at TRAIN cycle 10.
    task automatic test_idle_restart();
        enable = 1'b0;
        step();
        nCompared++;
        if ({state_out, active, data_out} !== {2'd0, 1'b0, IDL}) begin nMismatched++; $display("[TB] FAIL restart_leave got state=%0d active=%b data=%h want 0/0/%h", state_out, active, data_out, IDL); end
        enable = 1'b1;
        repeat (9) step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            nCompared++;
            if (state_out !== ((k < 16) ? 2'd0 : 2'd1)) begin nMismatched++; $display("[TB] FAIL restart_state k=%0d got %0d want %0d", k, state_out, (k < 16) ? 0 : 1); end
        end
    endtask

    // 100 back-to-back transfers spanning one SKP set, then reset mid-burst.
    task automatic test_back_to_back();
        int accepted = 0;
        int stalls   = 0;
        int cycles   = 0;
        nextByte = 8'h40;
        valid_in = 1'b1;
        while (accepted < 100 && cycles < 300) begin
            data_in = nextByte;
            step();
            cycles++;
            if (lastAcc) begin
                accepted++;
                nextByte++;
                if (expQ.size() > 0) expByte = expQ.pop_front(); else expByte = 'x;
                nCompared++;
                if (data_out !== expByte) begin nMismatched++; $display("[TB] FAIL b2b_data n=%0d got %h want %h", accepted, data_out, expByte); end
            end else begin
                stalls++;
                nCompared++;
                if (data_out !== SKP) begin nMismatched++; $display("[TB] FAIL b2b_stall_sym got %h want %h", data_out, SKP); end
            end
        end
        nCompared++;
        if (accepted != 100) begin nMismatched++; $display("[TB] FAIL b2b_timeout got %0d accepted want 100", accepted); end
        nCompared++;
        if (stalls != 4) begin nMismatched++; $display("[TB] FAIL b2b_stalls got %0d want 4", stalls); end
`ifdef CTRL_PS_STATS_EN
        nCompared++;
        if (stat_bytes !== 16'd100) begin nMismatched++; $display("[TB] FAIL stat_bytes got %0d want 100", stat_bytes); end
        nCompared++;
        if (stat_skp !== 16'd1) begin nMismatched++; $display("[TB] FAIL stat_skp got %0d want 1", stat_skp); end
`endif
        repeat (2) step();
        #2;
        reset_L = 1'b0;
        #1;
        nCompared++;
        if ({state_out, active, data_out, ready_out} !== {2'd0, 1'b0, IDL, 1'b0}) begin nMismatched++; $display("[TB] FAIL async_reset got state=%0d active=%b data=%h ready=%b want 0/0/%h/0", state_out, active, data_out, ready_out, IDL); end
`ifdef CTRL_PS_STATS_EN
        nCompared++;
        if ({stat_bytes, stat_skp} !== 32'd0) begin nMismatched++; $display("[TB] FAIL async_reset_stats got %h/%h want 0/0", stat_bytes, stat_skp); end
`endif
        expQ.delete();
        valid_in = 1'b0;
        @(posedge clk_4f);
        #2;
        reset_L = 1'b1;
        step();
        nCompared++;
        if (state_out !== 2'd0) begin nMismatched++; $display("[TB] FAIL post_reset_state got %0d want 0", state_out); end
    endtask

    initial begin
        test_reset();
        test_train();
        test_link_data();
        test_skp_insertion();
        test_enable_drop_skip();
        test_idle_restart();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Bound on the whole run in case the DUT never produces what a loop waits for.
    initial begin
        #100000;
        nMismatched++;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
